// File: rtl/pulse_period_monitor.sv
// ---------------------------------------------------------------------------
// pulse_period_monitor
//   Watchdog for a periodic tick source. It measures the number of clk cycles
//   between consecutive pulses on pulse_in and compares that interval with
//   the window [EXP_PERIOD-TOL, EXP_PERIOD+TOL]. It flags early pulses, and
//   missing pulses (timeouts). It declares lock after LOCK_CNT consecutive
//   good periods.
//
//   Interface semantics:
//     pulse_in is a level-sampled tick. Every cycle in which it is high
//     counts as one pulse, and it has no handshake. All outputs are
//     registered, so each one reflects the event sampled on the previous
//     edge. early_err and late_err are single-cycle strobes.
//     state_dbg exposes the FSM state for observation only.
// ---------------------------------------------------------------------------
module pulse_period_monitor #(
    parameter int EXP_PERIOD = 751,
    parameter int TOL        = 2,
    parameter int LOCK_CNT   = 4,
    parameter int CBITS      = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse_in,
    output logic             locked,
    output logic             early_err,
    output logic             late_err,
    output logic [CBITS-1:0] last_period,
    output logic [7:0]       err_count,
    output logic [1:0]       state_dbg
);

    // Width of the good-period counter. It must be able to hold LOCK_CNT.
    localparam int GBITS = $clog2(LOCK_CNT + 1);

    localparam logic [CBITS-1:0] WIN_LO  = CBITS'(EXP_PERIOD - TOL);
    localparam logic [CBITS-1:0] WIN_HI  = CBITS'(EXP_PERIOD + TOL);
    localparam logic [CBITS-1:0] CNT_MAX = {CBITS{1'b1}};
    localparam logic [CBITS-1:0] CNT_ONE = CBITS'(1);
    localparam logic [GBITS-1:0] LOCK_G  = GBITS'(LOCK_CNT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CBITS-1:0] cnt_q, cnt_d;
    logic [GBITS-1:0] good_q, good_d;
    logic             locked_q, locked_d;
    logic             early_q, early_d;
    logic             late_q, late_d;
    logic [CBITS-1:0] last_q, last_d;
    logic [7:0]       err_q, err_d;

    // Classification of the current cycle against the window. cnt_q is the
    // period P on a pulse cycle.
    logic             period_early;
    logic             period_good;
    logic             timeout;
    logic [GBITS-1:0] good_inc;
    logic             lock_reached;

    // Classify the current cycle and pre-compute the saturating good count.
    always_comb begin
        period_early = pulse_in && (cnt_q < WIN_LO);
        period_good  = pulse_in && (cnt_q >= WIN_LO) && (cnt_q <= WIN_HI);
        // A pulse that lands exactly on WIN_HI is good, so only a quiet
        // cycle at WIN_HI counts as a timeout.
        timeout      = !pulse_in && (cnt_q == WIN_HI);
        good_inc     = (good_q == LOCK_G) ? good_q : good_q + GBITS'(1);
        lock_reached = period_good && (good_inc == LOCK_G);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                // The first pulse only starts timing. It is not evaluated.
                if (pulse_in) begin
                    state_d = ST_ACQ;
                end
            end
            ST_ACQ: begin
                if (timeout) begin
                    state_d = ST_IDLE;
                end else if (lock_reached) begin
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (timeout) begin
                    state_d = ST_IDLE;
                end else if (period_early) begin
                    state_d = ST_ACQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM output and datapath logic: interval counter, good count, strobes,
    // last period, and error count.
    always_comb begin
        cnt_d    = cnt_q;
        good_d   = good_q;
        early_d  = 1'b0;
        late_d   = 1'b0;
        last_d   = last_q;
        err_d    = err_q;
        locked_d = (state_d == ST_LOCKED);

        if (state_q == ST_IDLE) begin
            // The counter is held at zero until the first pulse starts timing.
            cnt_d  = pulse_in ? CNT_ONE : '0;
            good_d = '0;
        end else if (pulse_in) begin
            // Every pulse restarts timing, whether it is good or early.
            cnt_d  = CNT_ONE;
            last_d = cnt_q;
            if (period_good) begin
                good_d = good_inc;
            end else if (period_early) begin
                early_d = 1'b1;
                good_d  = '0;
            end
        end else if (timeout) begin
            late_d = 1'b1;
            cnt_d  = '0;
            good_d = '0;
        end else begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
        end

        if ((early_d || late_d) && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
    end

    // Datapath and output registers. Reset discards any pending strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            good_q   <= '0;
            locked_q <= 1'b0;
            early_q  <= 1'b0;
            late_q   <= 1'b0;
            last_q   <= '0;
            err_q    <= '0;
        end else begin
            cnt_q    <= cnt_d;
            good_q   <= good_d;
            locked_q <= locked_d;
            early_q  <= early_d;
            late_q   <= late_d;
            last_q   <= last_d;
            err_q    <= err_d;
        end
    end

    assign locked      = locked_q;
    assign early_err   = early_q;
    assign late_err    = late_q;
    assign last_period = last_q;
    assign err_count   = err_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_pulse_period_monitor.sv
// ---------------------------------------------------------------------------
// tb_pulse_period_monitor
//   Directed bench for pulse_period_monitor with the default parameters.
//   The expected window is 749..753, lock needs 4 good periods, and the
//   timeout occurs at cnt 753.
// ---------------------------------------------------------------------------
module tb_pulse_period_monitor;

    localparam int CBITS = 11;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACQ    = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;

    logic             clk = 1'b0;
    logic             rst;
    logic             pulse_in;
    logic             locked;
    logic             early_err;
    logic             late_err;
    logic [CBITS-1:0] last_period;
    logic [7:0]       err_count;
    logic [1:0]       state_dbg;

    int n_checks = 0;
    int n_pass   = 0;
    int n_early  = 0;

    pulse_period_monitor dut (
        .clk        (clk),
        .rst        (rst),
        .pulse_in   (pulse_in),
        .locked     (locked),
        .early_err  (early_err),
        .late_err   (late_err),
        .last_period(last_period),
        .err_count  (err_count),
        .state_dbg  (state_dbg)
    );

    // clock
    always #5 clk = ~clk;

    // single checking task: counts every comparison, reports mismatches
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // advance one clock edge; outputs are observed 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        pulse_in = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse();
        pulse_in = 1'b1;
        tick();
        pulse_in = 1'b0;
    endtask

    // next pulse arrives p cycles after the previous one
    task automatic gap(input int p);
        idle(p - 1);
        pulse();
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        pulse_in = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_locked"}, 32'(locked), 0);
        check({tag, "_early"},  32'(early_err), 0);
        check({tag, "_late"},   32'(late_err), 0);
        check({tag, "_last"},   32'(last_period), 0);
        check({tag, "_errcnt"}, 32'(err_count), 0);
        check({tag, "_state"},  32'(state_dbg), 32'(S_IDLE));
    endtask

    initial begin
        rst      = 1'b1;
        pulse_in = 1'b0;
        tick();
        tick();
        check_cleared("reset");
        rst = 1'b0;

        // 1: nominal acquisition at period 751
        pulse();
        check("t1_first_state", 32'(state_dbg), 32'(S_ACQ));
        check("t1_first_last",  32'(last_period), 0);
        for (int k = 2; k <= 5; k++) begin
            gap(751);
            check($sformatf("t1_p%0d_last", k),  32'(last_period), 751);
            check($sformatf("t1_p%0d_early", k), 32'(early_err), 0);
            check($sformatf("t1_p%0d_locked", k), 32'(locked), (k == 5) ? 1 : 0);
        end
        check("t1_state", 32'(state_dbg), 32'(S_LOCKED));

        // 2: window edges while locked
        gap(749);
        check("t2_749_locked", 32'(locked), 1);
        check("t2_749_early",  32'(early_err), 0);
        check("t2_749_last",   32'(last_period), 749);
        gap(753);
        check("t2_753_locked", 32'(locked), 1);
        check("t2_753_late",   32'(late_err), 0);
        check("t2_753_last",   32'(last_period), 753);
        gap(748);
        check("t2_748_early",  32'(early_err), 1);
        check("t2_748_locked", 32'(locked), 0);
        check("t2_748_errcnt", 32'(err_count), 1);
        check("t2_748_state",  32'(state_dbg), 32'(S_ACQ));
        tick();
        check("t2_early_1cyc", 32'(early_err), 0);

        // 3: relock (the early pulse restarted timing), then pulses stop
        idle(749);
        pulse();
        gap(751);
        gap(751);
        check("t3_relock_pre", 32'(locked), 0);
        gap(751);
        check("t3_relock", 32'(locked), 1);
        idle(752);
        check("t3_752_late",   32'(late_err), 0);
        check("t3_752_locked", 32'(locked), 1);
        tick();
        check("t3_late",   32'(late_err), 1);
        check("t3_early",  32'(early_err), 0);
        check("t3_locked", 32'(locked), 0);
        check("t3_state",  32'(state_dbg), 32'(S_IDLE));
        check("t3_errcnt", 32'(err_count), 2);
        tick();
        check("t3_late_1cyc", 32'(late_err), 0);

        // 4: re-acquire; the first pulse after the timeout is not evaluated
        idle(9);
        pulse();
        check("t4_first_state", 32'(state_dbg), 32'(S_ACQ));
        check("t4_first_last",  32'(last_period), 751);
        check("t4_first_early", 32'(early_err), 0);
        for (int k = 2; k <= 5; k++) begin
            gap(751);
            check($sformatf("t4_p%0d_locked", k), 32'(locked), (k == 5) ? 1 : 0);
        end
        check("t4_errcnt", 32'(err_count), 2);

        // 5: single-cycle reset while locked
        do_reset();
        check_cleared("t5_rst");
        pulse();
        for (int k = 2; k <= 5; k++) begin
            gap(751);
            check($sformatf("t5_p%0d_locked", k), 32'(locked), (k == 5) ? 1 : 0);
        end

        // 6: pulse held high for 301 cycles -> 300 early errors
        do_reset();
        pulse_in = 1'b1;
        for (int k = 1; k <= 301; k++) begin
            tick();
            if (early_err) n_early++;
            if (k == 1)   check("t6_first_early", 32'(early_err), 0);
            if (k == 2)   check("t6_second_errcnt", 32'(err_count), 1);
            if (k == 255) check("t6_254", 32'(err_count), 254);
            if (k == 256) check("t6_255", 32'(err_count), 255);
        end
        check("t6_early_strobes", 32'(n_early), 300);
        check("t6_last", 32'(last_period), 1);
        pulse_in = 1'b0;
        tick();
        check("t6_sat_errcnt", 32'(err_count), 255);
        check("t6_early_off", 32'(early_err), 0);
        check("t6_late_off",  32'(late_err), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
